// File: rtl/game_pkg.sv
// Shared constants and phase encoding for the whack-a-mole sequencer.
// Everything here is imported by game_sequencer.
package game_pkg;
  localparam int NUM_MOLES     = 5;
  localparam int COUNTDOWN_SEC = 5;
  localparam int GAME_SEC      = 30;
  localparam int SCORE_W       = 6;
  localparam int SCORE_MAX     = 63;

  typedef enum logic [1:0] {
    PH_IDLE     = 2'd0,
    PH_PRESTART = 2'd1,
    PH_PLAY     = 2'd2,
    PH_DONE     = 2'd3
  } phase_e;
endpackage

// File: rtl/edge_sync.sv
// Optional 2-flop synchronizer followed by a rising-edge pulse generator.
// With SYNC = 0 the input is assumed synchronous and only the edge stage is built.
module edge_sync #(
  parameter int W    = 1,
  parameter bit SYNC = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);
  logic [W-1:0] level;
  logic [W-1:0] prev;

  generate
    if (SYNC) begin : g_sync
      logic [W-1:0] meta;
      logic [W-1:0] stable;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          meta   <= '0;
          stable <= '0;
        end else begin
          meta   <= d;
          stable <= meta;
        end
      end
      assign level = stable;
    end else begin : g_nosync
      assign level = d;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= '0;
    else       prev <= level;
  end

  assign rise = level & ~prev;
endmodule

// File: rtl/game_sequencer.sv
// Whack-a-mole controller: countdown, timed play round with mole selection
// and hit scoring, then score hold. All outputs are registered.
//
// state       | meaning
// PH_IDLE     | waiting for start, display blank
// PH_PRESTART | counting down, display shows seconds left
// PH_PLAY     | mole lit, hits scored, display shows score
// PH_DONE     | round over, score held, game_over high
module game_sequencer #(
  parameter int NUM_MOLES     = game_pkg::NUM_MOLES,
  parameter int COUNTDOWN_SEC = game_pkg::COUNTDOWN_SEC,
  parameter int GAME_SEC      = game_pkg::GAME_SEC,
  parameter int SCORE_W       = game_pkg::SCORE_W,
  parameter int SCORE_MAX     = game_pkg::SCORE_MAX
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_1hz,
  input  logic                 start,
  input  logic [2:0]           rand_val,
  input  logic [NUM_MOLES-1:0] switch_in,
  output logic [NUM_MOLES-1:0] mole,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   time_left,
  output logic [SCORE_W-1:0]   disp_value,
  output logic [1:0]           phase,
  output logic                 game_over
);
  import game_pkg::*;

  localparam int IDX_W = $clog2(NUM_MOLES);

  phase_e               state_q, state_d;
  logic [NUM_MOLES-1:0] sw_rise, mole_d, new_mole;
  logic [SCORE_W-1:0]   score_d, time_d, disp_d, score_inc;
  logic [IDX_W-1:0]     rand_idx, new_idx;
  logic                 start_rise, hit, last_tick;

  edge_sync #(.W(NUM_MOLES), .SYNC(1'b1)) u_sw_sync (
    .clk(clk), .reset(reset), .d(switch_in), .rise(sw_rise)
  );

  edge_sync #(.W(1), .SYNC(1'b0)) u_start_edge (
    .clk(clk), .reset(reset), .d(start), .rise(start_rise)
  );

  // Never relight the mole that is currently lit.
  always_comb begin
    rand_idx = IDX_W'(int'(rand_val) % NUM_MOLES);
    new_idx  = rand_idx;
    if (mole[rand_idx])
      new_idx = (rand_idx == IDX_W'(NUM_MOLES - 1)) ? '0 : rand_idx + IDX_W'(1);
    new_mole = NUM_MOLES'(1) << new_idx;
  end

  assign hit       = |(sw_rise & mole);
  assign last_tick = tick_1hz && (time_left == SCORE_W'(1));
  assign score_inc = (score == SCORE_W'(SCORE_MAX)) ? score : score + SCORE_W'(1);

  always_comb begin
    state_d = state_q;
    mole_d  = mole;
    score_d = score;
    time_d  = time_left;
    disp_d  = score;
    case (state_q)
      PH_IDLE: begin
        disp_d = '0;
        if (start_rise) begin
          state_d = PH_PRESTART;
          time_d  = SCORE_W'(COUNTDOWN_SEC);
        end
      end
      PH_PRESTART: begin
        disp_d = time_left;
        if (last_tick) begin
          state_d = PH_PLAY;
          time_d  = SCORE_W'(GAME_SEC);
          score_d = '0;
          mole_d  = new_mole;
        end else if (tick_1hz) begin
          time_d = time_left - SCORE_W'(1);
        end
      end
      PH_PLAY: begin
        if (hit) score_d = score_inc;
        if (last_tick) begin
          state_d = PH_DONE;
          mole_d  = '0;
          time_d  = '0;
        end else begin
          if (tick_1hz)        time_d = time_left - SCORE_W'(1);
          if (tick_1hz || hit) mole_d = new_mole;
        end
      end
      PH_DONE: begin
        if (start_rise) begin
          state_d = PH_PRESTART;
          time_d  = SCORE_W'(COUNTDOWN_SEC);
        end
      end
      default: state_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= PH_IDLE;
      mole       <= '0;
      score      <= '0;
      time_left  <= '0;
      disp_value <= '0;
      game_over  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mole       <= mole_d;
      score      <= score_d;
      time_left  <= time_d;
      disp_value <= disp_d;
      game_over  <= (state_d == PH_DONE);
    end
  end

  assign phase = state_q;
endmodule
